accumulate_sequencer: RTL and testbench
=======================================

Name: accumulate_sequencer

Overview:
- Control FSM for the bit-serial accumulator datapath on the switch/LED/hex board.
- Takes the Run_Accumulate push-button (asynchronous, level), synchronizes it, and detects its rising edge.
- Each press sequences exactly one SW-operand load followed by WIDTH shift/add cycles, then waits for the button to be released.
- Also drives the accumulator clear and a sticky unsigned-overflow flag.

Parameters:
- WIDTH, 16, accumulator width in bits; equals the number of serial add cycles.
- SYNC_STAGES, 2, number of flops in the Run_Accumulate synchronizer (minimum 2).

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- Reset_Clear  in  1  synchronous, active-high reset; also commands the accumulator clear.
- Run_Accumulate  in  1  raw button, active-high, asynchronous to Clk.
- Carry_Out  in  1  carry out of the datapath's 1-bit full adder in the current cycle.
- Ld_Operand  out  1  load the SW operand into the datapath B register.
- Carry_Clr  out  1  clear the datapath carry flop.
- Shift_En  out  1  shift the A/B registers one bit and write back the sum bit.
- Acc_Clr  out  1  clear the accumulator register.
- Bit_Index  out  $clog2(WIDTH)  current serial bit position.
- Busy  out  1  high while in LOAD, SHIFT or DONE.
- Done  out  1  one-cycle pulse when an accumulate completes.
- Overflow  out  1  sticky; set when any accumulate carries out of the MSB.

Behaviour:
- Reset: Clk and Reset_Clear only; the reset is synchronous and active-high.
  - While Reset_Clear is sampled high: state = IDLE, Bit_Index = 0, Overflow = 0, Acc_Clr = 1.
  - While Reset_Clear is sampled high: Ld_Operand, Carry_Clr, Shift_En, Busy and Done = 0.
  - Reset_Clear is honoured in every state, including mid-SHIFT. A partial accumulate is abandoned and no Done is produced.
- Synchronizer: a SYNC_STAGES flop chain produces run_s; a further flop produces run_prev. run_rise = run_s & ~run_prev.
  - On reset, every synchronizer flop and run_prev load 1. A button held through reset therefore produces no edge; it must be released and pressed again.
- States:
  - IDLE: all strobes 0. On run_rise, go to LOAD.
  - LOAD: one cycle. Ld_Operand = 1, Carry_Clr = 1, Bit_Index = 0. Go to SHIFT.
  - SHIFT: Shift_En = 1; Bit_Index counts 0 to WIDTH-1, one increment per cycle. When Bit_Index == WIDTH-1: Overflow |= Carry_Out, Bit_Index wraps to 0, go to DONE.
  - DONE: one cycle. Done = 1. Go to HOLD.
  - HOLD: all strobes 0. Once run_s == 0, go to IDLE.
- Latency:
  - First Clk edge sampling Run_Accumulate high = edge 0.
  - run_rise is high in the cycle after edge SYNC_STAGES.
  - LOAD occurs one cycle after run_rise, i.e. SYNC_STAGES+2 cycles after edge 0.
  - SHIFT runs for exactly WIDTH cycles; Done is high WIDTH+1 cycles after LOAD.
- Busy = (state ∈ {LOAD, SHIFT, DONE}).
- Run_Accumulate activity during LOAD/SHIFT/DONE is ignored; no edge is queued.
  - If the button is released before DONE, HOLD exits after one cycle.
- Carry_Out is ignored everywhere except the final SHIFT cycle.
- Overflow is cleared only by Reset_Clear.
- Acc_Clr is driven only by Reset_Clear and follows it combinationally with no added cycle delay.
- Simultaneous events: Reset_Clear has priority over run_rise and over every state transition.

Decomposition:
- Shared package accumulate_pkg:
  - state enum acc_state_t with values IDLE, LOAD, SHIFT, DONE, HOLD.
  - constant DEFAULT_SYNC_STAGES = 2.
- One sub-module, run_sync_edge: parameterized synchronizer plus rising-edge detector, with reset-to-1. The board's other button inputs reuse it.
- The FSM, counter and Overflow register live in accumulate_sequencer.

Test Plan:
All scenarios use WIDTH = 16 and SYNC_STAGES = 2.
1. Single press. Hold Reset_Clear for 2 cycles, release it, then raise Run_Accumulate at edge 0 and hold it for 30 cycles.
   - Ld_Operand and Carry_Clr are high at cycle 4 only.
   - Shift_En is high for cycles 5–20 with Bit_Index 0…15.
   - Done is high at cycle 21 only; Busy is high for cycles 4–21; the FSM stays in HOLD until release.
2. Overflow. Tie Carry_Out = 1 and press once.
   - Overflow rises the cycle after the last SHIFT cycle and stays 1 across a second press with Carry_Out = 0.
   - It clears on Reset_Clear.
   - With Carry_Out = 1 on any non-final SHIFT cycle only, Overflow stays 0.
3. Reset mid-operation. Assert Reset_Clear at Bit_Index = 7.
   - In the same cycle Acc_Clr = 1, with Shift_En = 0 and Busy = 0.
   - Bit_Index is 0, no Done ever appears, and Overflow = 0.
4. Button held through reset. Run_Accumulate is high before and during Reset_Clear and stays high for 40 cycles afterwards.
   - No Ld_Operand occurs.
   - Releasing for 4 cycles and then pressing starts exactly one sequence.
5. Bounce and early release.
   - Toggling Run_Accumulate every cycle during SHIFT changes no strobes and produces no second LOAD.
   - Releasing at Bit_Index = 3 gives HOLD→IDLE one cycle after DONE.
   - A subsequent clean press gives LOAD at cycle 4 relative to the new edge 0.
6. Back-to-back presses. Apply 8-cycle presses 30 cycles apart.
   - Each press produces exactly one LOAD/16×SHIFT/DONE sequence.
   - Bit_Index starts at 0 each time.

Source files
------------

// File: rtl/accumulate_pkg.sv
// Shared types and constants for the bit-serial accumulator control path.
package accumulate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        HOLD
    } acc_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/run_sync_edge.sv
// Push-button synchronizer with a registered rising-edge pulse.
// Resets to "pressed" so a button held through reset never yields an edge.
module run_sync_edge
    import accumulate_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;
    logic                   rise_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '1;
            prev_p1 <= 1'b1;
            rise_p2 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn};
            // sync -> prev/edge boundary
            prev_p1 <= sync_p0[SYNC_STAGES-1];
            rise_p2 <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
        end
    end

    assign level = sync_p0[SYNC_STAGES-1];
    assign rise  = rise_p2;

endmodule

// File: rtl/accumulate_sequencer.sv
// Control FSM for the bit-serial accumulator: one operand load, WIDTH
// shift/add cycles per button press, plus accumulator clear and sticky overflow.
module accumulate_sequencer
    import accumulate_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                     Clk,
    input  logic                     Reset_Clear,
    input  logic                     Run_Accumulate,
    input  logic                     Carry_Out,
    output logic                     Ld_Operand,
    output logic                     Carry_Clr,
    output logic                     Shift_En,
    output logic                     Acc_Clr,
    output logic [$clog2(WIDTH)-1:0] Bit_Index,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Overflow
);

    localparam int                IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(WIDTH - 1);

    acc_state_t        state_q;
    acc_state_t        state_d;
    logic [IDX_W-1:0]  bit_cnt_q;
    logic              ovf_q;
    logic              run_s;
    logic              run_rise;
    logic              last_bit;

    run_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_run_sync (
        .clk  (Clk),
        .rst  (Reset_Clear),
        .btn  (Run_Accumulate),
        .level(run_s),
        .rise (run_rise)
    );

    assign last_bit = (bit_cnt_q == LAST_BIT);

    always_ff @(posedge Clk) begin
        if (Reset_Clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Carry_Out only matters on the final serial bit: that is the MSB carry.
    always_ff @(posedge Clk) begin
        if (Reset_Clear) begin
            bit_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                bit_cnt_q <= '0;
                ovf_q     <= ovf_q | Carry_Out;
            end else begin
                bit_cnt_q <= bit_cnt_q + IDX_W'(1);
            end
        end else if (state_q == LOAD) begin
            bit_cnt_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run_rise) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = HOLD;
            HOLD:    if (!run_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates every strobe in the same cycle, before the state register follows.
    always_comb begin
        Ld_Operand = 1'b0;
        Carry_Clr  = 1'b0;
        Shift_En   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        Acc_Clr    = Reset_Clear;
        Bit_Index  = Reset_Clear ? '0 : bit_cnt_q;
        Overflow   = ovf_q & ~Reset_Clear;
        if (!Reset_Clear) begin
            case (state_q)
                LOAD: begin
                    Ld_Operand = 1'b1;
                    Carry_Clr  = 1'b1;
                    Busy       = 1'b1;
                end
                SHIFT: begin
                    Shift_En = 1'b1;
                    Busy     = 1'b1;
                end
                DONE: begin
                    Done = 1'b1;
                    Busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulate_sequencer.sv
// Directed bench for accumulate_sequencer (WIDTH=16, SYNC_STAGES=2).
// Cycle k is the clock period that ends at edge k; edge 0 first samples the press.
module tb_accumulate_sequencer;
    import accumulate_pkg::*;

    logic       clk = 1'b0;
    logic       Reset_Clear = 1'b1;
    logic       Run_Accumulate = 1'b0;
    logic       Carry_Out = 1'b0;
    logic       Ld_Operand, Carry_Clr, Shift_En, Acc_Clr, Busy, Done, Overflow;
    logic [3:0] Bit_Index;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    accumulate_sequencer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .Clk(clk), .Reset_Clear(Reset_Clear), .Run_Accumulate(Run_Accumulate),
        .Carry_Out(Carry_Out), .Ld_Operand(Ld_Operand), .Carry_Clr(Carry_Clr),
        .Shift_En(Shift_En), .Acc_Clr(Acc_Clr), .Bit_Index(Bit_Index),
        .Busy(Busy), .Done(Done), .Overflow(Overflow)
    );

    task automatic settle();
        Run_Accumulate = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        Reset_Clear = 1'b1;
        repeat (2) @(negedge clk);
        Reset_Clear = 1'b0;
    endtask

    // Raises the button now (caller sits on a negedge) and tallies strobes.
    task automatic press_observe(input int cycles, input int release_at,
                                 output int loads, output int shifts, output int dones,
                                 output int load_cyc, output int first_bi, output int bad_bi);
        loads = 0; shifts = 0; dones = 0; load_cyc = -1; first_bi = -1; bad_bi = 0;
        Run_Accumulate = 1'b1;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (Ld_Operand) begin
                if (load_cyc < 0) load_cyc = k;
                loads++;
            end
            if (Shift_En) begin
                if (shifts == 0) first_bi = int'(Bit_Index);
                if (Bit_Index !== 4'(shifts)) bad_bi++;
                shifts++;
            end
            if (Done) dones++;
            if (k == release_at) Run_Accumulate = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset_Clear = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++; if (Acc_Clr !== 1'b1) $display("FAIL reset_acc_clr got=%b exp=1", Acc_Clr); else pass_cnt++;
        total_cnt++;
        if ({Ld_Operand, Carry_Clr, Shift_En, Busy, Done} !== 5'b0)
            $display("FAIL reset_strobes got=%b exp=00000", {Ld_Operand, Carry_Clr, Shift_En, Busy, Done});
        else pass_cnt++;
        total_cnt++; if (Bit_Index !== 4'd0) $display("FAIL reset_bit_index got=%0d exp=0", Bit_Index); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", Overflow); else pass_cnt++;
        total_cnt++; if (dut.state_q !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); else pass_cnt++;
        @(negedge clk);
        Reset_Clear = 1'b0;
        #1;
        total_cnt++; if (Acc_Clr !== 1'b0) $display("FAIL acc_clr_release got=%b exp=0", Acc_Clr); else pass_cnt++;
    endtask

    task automatic test_single_press();
        logic [4:0] got, exp;
        logic [3:0] bi_exp;
        settle();
        Run_Accumulate = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            got = {Ld_Operand, Carry_Clr, Shift_En, Done, Busy};
            exp = {k == 4, k == 4, (k >= 5 && k <= 20), k == 21, (k >= 4 && k <= 21)};
            bi_exp = (k >= 5 && k <= 20) ? 4'(k - 5) : 4'd0;
            total_cnt++; if (got !== exp) $display("FAIL single_strobes cyc=%0d got=%b exp=%b", k, got, exp); else pass_cnt++;
            total_cnt++; if (Bit_Index !== bi_exp) $display("FAIL single_bit_index cyc=%0d got=%0d exp=%0d", k, Bit_Index, bi_exp); else pass_cnt++;
        end
        total_cnt++; if (dut.state_q !== HOLD) $display("FAIL single_hold got=%0d exp=%0d", dut.state_q, HOLD); else pass_cnt++;
        Run_Accumulate = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++; if (dut.state_q !== IDLE) $display("FAIL single_release got=%0d exp=%0d", dut.state_q, IDLE); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int l, s, d, lc, fb, bb;
        settle();
        Carry_Out = 1'b1;
        Run_Accumulate = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 20) begin
                total_cnt++; if (Overflow !== 1'b0) $display("FAIL ovf_before_last got=%b exp=0", Overflow); else pass_cnt++;
            end
            if (k == 21) begin
                total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_after_last got=%b exp=1", Overflow); else pass_cnt++;
            end
        end
        Carry_Out = 1'b0;
        settle();
        press_observe(30, 8, l, s, d, lc, fb, bb);
        total_cnt++; if (d !== 1) $display("FAIL ovf_second_done got=%0d exp=1", d); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", Overflow); else pass_cnt++;
        Reset_Clear = 1'b1;
        @(negedge clk);
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL ovf_reset_clear got=%b exp=0", Overflow); else pass_cnt++;
        @(negedge clk);
        Reset_Clear = 1'b0;
        settle();
        // Carry asserted on every serial bit except the MSB.
        Run_Accumulate = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            Carry_Out = Shift_En && (Bit_Index != 4'd15);
            if (k == 8) Run_Accumulate = 1'b0;
        end
        Carry_Out = 1'b0;
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL ovf_nonfinal_carry got=%b exp=0", Overflow); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int l, s, d, lc, fb, bb;
        int dones, loads;
        bit found;
        settle();
        Carry_Out = 1'b1;
        press_observe(30, 8, l, s, d, lc, fb, bb);
        Carry_Out = 1'b0;
        total_cnt++; if (Overflow !== 1'b1) $display("FAIL mid_pre_ovf got=%b exp=1", Overflow); else pass_cnt++;
        settle();
        Run_Accumulate = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (Shift_En && Bit_Index == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        total_cnt++; if (found !== 1'b1) $display("FAIL mid_reach_bit7 got=%b exp=1", found); else pass_cnt++;
        Reset_Clear = 1'b1;
        #1;
        total_cnt++;
        if ({Acc_Clr, Shift_En, Busy} !== 3'b100)
            $display("FAIL mid_same_cycle got=%b exp=100", {Acc_Clr, Shift_En, Busy});
        else pass_cnt++;
        total_cnt++; if (Bit_Index !== 4'd0) $display("FAIL mid_bit_index got=%0d exp=0", Bit_Index); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL mid_overflow got=%b exp=0", Overflow); else pass_cnt++;
        repeat (2) @(negedge clk);
        Reset_Clear = 1'b0;
        dones = 0; loads = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (Done) dones++;
            if (Ld_Operand) loads++;
        end
        total_cnt++; if (dones !== 0) $display("FAIL mid_no_done got=%0d exp=0", dones); else pass_cnt++;
        total_cnt++; if (loads !== 0) $display("FAIL mid_no_reload got=%0d exp=0", loads); else pass_cnt++;
        total_cnt++; if (Overflow !== 1'b0) $display("FAIL mid_ovf_after got=%b exp=0", Overflow); else pass_cnt++;
    endtask

    task automatic test_held_through_reset();
        int l, s, d, lc, fb, bb;
        settle();
        Run_Accumulate = 1'b1;
        @(negedge clk);
        do_reset();
        press_observe(40, 0, l, s, d, lc, fb, bb);
        total_cnt++; if (l !== 0) $display("FAIL held_no_load got=%0d exp=0", l); else pass_cnt++;
        Run_Accumulate = 1'b0;
        repeat (4) @(negedge clk);
        press_observe(30, 8, l, s, d, lc, fb, bb);
        total_cnt++; if (l !== 1) $display("FAIL held_repress_loads got=%0d exp=1", l); else pass_cnt++;
        total_cnt++; if (lc !== 4) $display("FAIL held_repress_load_cyc got=%0d exp=4", lc); else pass_cnt++;
        total_cnt++; if (d !== 1) $display("FAIL held_repress_done got=%0d exp=1", d); else pass_cnt++;
    endtask

    task automatic test_bounce();
        int l, s, d, lc, fb, bb;
        int loads, shifts;
        settle();
        loads = 0; shifts = 0;
        Run_Accumulate = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (Ld_Operand) loads++;
            if (Shift_En) shifts++;
            if (k >= 5 && k <= 20) begin
                total_cnt++;
                if ({Ld_Operand, Shift_En, Done} !== 3'b010)
                    $display("FAIL bounce_strobes cyc=%0d got=%b exp=010", k, {Ld_Operand, Shift_En, Done});
                else pass_cnt++;
            end
            if (k == 22) begin
                total_cnt++; if (dut.state_q !== HOLD) $display("FAIL bounce_hold got=%0d exp=%0d", dut.state_q, HOLD); else pass_cnt++;
            end
            if (k == 23) begin
                total_cnt++; if (dut.state_q !== IDLE) $display("FAIL bounce_idle got=%0d exp=%0d", dut.state_q, IDLE); else pass_cnt++;
            end
            if (k >= 5 && k <= 7) Run_Accumulate = ~Run_Accumulate;
            if (k == 8) Run_Accumulate = 1'b0;
        end
        total_cnt++; if (loads !== 1) $display("FAIL bounce_loads got=%0d exp=1", loads); else pass_cnt++;
        total_cnt++; if (shifts !== 16) $display("FAIL bounce_shifts got=%0d exp=16", shifts); else pass_cnt++;
        settle();
        press_observe(30, 8, l, s, d, lc, fb, bb);
        total_cnt++; if (lc !== 4) $display("FAIL bounce_clean_load_cyc got=%0d exp=4", lc); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int l, s, d, lc, fb, bb;
        settle();
        for (int p = 0; p < 3; p++) begin
            press_observe(30, 8, l, s, d, lc, fb, bb);
            total_cnt++; if (l !== 1) $display("FAIL b2b_loads press=%0d got=%0d exp=1", p, l); else pass_cnt++;
            total_cnt++; if (s !== 16) $display("FAIL b2b_shifts press=%0d got=%0d exp=16", p, s); else pass_cnt++;
            total_cnt++; if (d !== 1) $display("FAIL b2b_dones press=%0d got=%0d exp=1", p, d); else pass_cnt++;
            total_cnt++; if (fb !== 0) $display("FAIL b2b_first_bit press=%0d got=%0d exp=0", p, fb); else pass_cnt++;
            total_cnt++; if (bb !== 0) $display("FAIL b2b_bit_seq press=%0d got=%0d exp=0", p, bb); else pass_cnt++;
            total_cnt++; if (lc !== 4) $display("FAIL b2b_load_cyc press=%0d got=%0d exp=4", p, lc); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_overflow();
        test_reset_mid();
        test_held_through_reset();
        test_bounce();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
